// File: rtl/seq_bin_to_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one iteration per clock).
// Takes start/bin_in, runs BIN_W iterations, then updates bcd_out/neg/overflow
// and pulses done for one cycle. Signed operands are converted by magnitude.
module seq_bin_to_bcd #(
    parameter int BIN_W       = 16,
    parameter int DIGITS      = 5,
    parameter int SIGNED_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  neg,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [BIN_W-1:0] mag;
    logic [BCD_W-1:0] dig;
    logic [CNT_W-1:0] cnt;
    logic             sign_pend;
    logic             ovf_pend;

    logic             capture;
    logic [BIN_W-1:0] mag_in;
    logic             sign_in;
    logic [BCD_W-1:0] dig_adj;

    // Add 3 to every digit that is 5 or more; each digit wraps in 4 bits on its own.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] r;
        r = d;
        for (int i = 0; i < DIGITS; i++) begin
            if (d[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = d[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Magnitude of the operand; the most negative value maps to 2^(BIN_W-1).
    function automatic logic [BIN_W-1:0] magnitude(input logic signed [BIN_W-1:0] v);
        logic signed [BIN_W-1:0] n;
        n = -v;
        if ((SIGNED_MODE != 0) && v[BIN_W-1]) begin
            return $unsigned(n);
        end
        return $unsigned(v);
    endfunction

    assign mag_in  = magnitude($signed(bin_in));
    // A negative two's-complement value always has a nonzero magnitude.
    assign sign_in = (SIGNED_MODE != 0) && bin_in[BIN_W-1];
    assign dig_adj = add3_digits(dig);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic, busy and operand-capture strobe.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                busy = 1'b1;
                if (cnt == LAST_ITER) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = CONV;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Working registers: capture operand, then one add-3/shift iteration per CONV cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag       <= '0;
            dig       <= '0;
            cnt       <= '0;
            sign_pend <= 1'b0;
            ovf_pend  <= 1'b0;
        end else if (capture) begin
            mag       <= mag_in;
            dig       <= '0;
            cnt       <= '0;
            sign_pend <= sign_in;
            ovf_pend  <= 1'b0;
        end else if (state == CONV) begin
            dig <= {dig_adj[BCD_W-2:0], mag[BIN_W-1]};
            mag <= {mag[BIN_W-2:0], 1'b0};
            cnt <= cnt + 1'b1;
            // A 1 leaving the top digit means the result needs more digits.
            if (dig_adj[BCD_W-1]) begin
                ovf_pend <= 1'b1;
            end
        end
    end

    // Result registers: updated only from the DONE state, so no intermediate values show.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done     <= 1'b0;
            bcd_out  <= '0;
            neg      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (state == DONE) begin
                bcd_out  <= dig;
                neg      <= sign_pend;
                overflow <= ovf_pend;
            end
        end
    end

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Directed testbench for seq_bin_to_bcd: unsigned default, signed and 4-digit instances.
module tb_seq_bin_to_bcd;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic        start_a [3];
    logic [15:0] bin_a   [3];
    logic        busy_a  [3];
    logic        done_a  [3];
    logic        neg_a   [3];
    logic        ovf_a   [3];
    logic [19:0] bcd_a   [3];

    logic        busy0, done0, neg0, ovf0;
    logic        busy1, done1, neg1, ovf1;
    logic        busy2, done2, neg2, ovf2;
    logic [19:0] bcd0, bcd1;
    logic [15:0] bcd2;

    int errors = 0;
    int checks = 0;

    seq_bin_to_bcd #(.BIN_W(16), .DIGITS(5), .SIGNED_MODE(0)) u_uns (
        .clk(clk), .rst_n(rst_n), .start(start_a[0]), .bin_in(bin_a[0]),
        .busy(busy0), .done(done0), .bcd_out(bcd0), .neg(neg0), .overflow(ovf0)
    );

    seq_bin_to_bcd #(.BIN_W(16), .DIGITS(5), .SIGNED_MODE(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .start(start_a[1]), .bin_in(bin_a[1]),
        .busy(busy1), .done(done1), .bcd_out(bcd1), .neg(neg1), .overflow(ovf1)
    );

    seq_bin_to_bcd #(.BIN_W(16), .DIGITS(4), .SIGNED_MODE(0)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start_a[2]), .bin_in(bin_a[2]),
        .busy(busy2), .done(done2), .bcd_out(bcd2), .neg(neg2), .overflow(ovf2)
    );

    assign busy_a[0] = busy0;
    assign busy_a[1] = busy1;
    assign busy_a[2] = busy2;
    assign done_a[0] = done0;
    assign done_a[1] = done1;
    assign done_a[2] = done2;
    assign neg_a[0]  = neg0;
    assign neg_a[1]  = neg1;
    assign neg_a[2]  = neg2;
    assign ovf_a[0]  = ovf0;
    assign ovf_a[1]  = ovf1;
    assign ovf_a[2]  = ovf2;
    assign bcd_a[0]  = bcd0;
    assign bcd_a[1]  = bcd1;
    assign bcd_a[2]  = {4'h0, bcd2};

    // Pulse start for one cycle, then wait (bounded) for done; lat counts edges after the start edge.
    task automatic run_conv(input int u, input logic [15:0] v, output int lat);
        @(negedge clk);
        start_a[u] = 1'b1;
        bin_a[u]   = v;
        @(negedge clk);
        start_a[u] = 1'b0;
        lat = 0;
        while (done_a[u] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int u = 0; u < 3; u++) begin
            start_a[u] = 1'b0;
            bin_a[u]   = '0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (busy_a[u] !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy[%0d]: got %b want 0", u, busy_a[u]);
            end
            checks++;
            if (done_a[u] !== 1'b0) begin
                errors++;
                $display("FAIL reset_done[%0d]: got %b want 0", u, done_a[u]);
            end
            checks++;
            if (bcd_a[u] !== 20'h00000) begin
                errors++;
                $display("FAIL reset_bcd[%0d]: got %h want 00000", u, bcd_a[u]);
            end
            checks++;
            if (neg_a[u] !== 1'b0 || ovf_a[u] !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags[%0d]: got neg=%b ovf=%b want 0 0", u, neg_a[u], ovf_a[u]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned_max();
        int lat;
        run_conv(0, 16'hFFFF, lat);
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("FAIL max_latency: got %0d want 17", lat);
        end
        checks++;
        if (bcd_a[0] !== 20'h65535) begin
            errors++;
            $display("FAIL max_bcd: got %h want 65535", bcd_a[0]);
        end
        checks++;
        if (ovf_a[0] !== 1'b0 || neg_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL max_flags: got ovf=%b neg=%b want 0 0", ovf_a[0], neg_a[0]);
        end
        @(negedge clk);
        checks++;
        if (done_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL done_width: got %b want 0", done_a[0]);
        end
    endtask

    task automatic test_unsigned_values();
        int lat;
        run_conv(0, 16'd0, lat);
        checks++;
        if (bcd_a[0] !== 20'h00000 || ovf_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL zero: got bcd=%h ovf=%b want 00000 0", bcd_a[0], ovf_a[0]);
        end
        run_conv(0, 16'd9999, lat);
        checks++;
        if (bcd_a[0] !== 20'h09999 || lat !== 17) begin
            errors++;
            $display("FAIL val9999: got bcd=%h lat=%0d want 09999 17", bcd_a[0], lat);
        end
    endtask

    task automatic test_signed();
        logic [15:0] vin  [4];
        logic        vneg [4];
        logic [19:0] vbcd [4];
        int lat;
        vin  = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000};
        vneg = '{1'b1, 1'b1, 1'b0, 1'b0};
        vbcd = '{20'h32768, 20'h00001, 20'h32767, 20'h00000};
        for (int i = 0; i < 4; i++) begin
            run_conv(1, vin[i], lat);
            checks++;
            if (bcd_a[1] !== vbcd[i] || neg_a[1] !== vneg[i] || ovf_a[1] !== 1'b0) begin
                errors++;
                $display("FAIL signed_%h: got bcd=%h neg=%b ovf=%b want %h %b 0",
                         vin[i], bcd_a[1], neg_a[1], ovf_a[1], vbcd[i], vneg[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int lat;
        run_conv(2, 16'd12345, lat);
        checks++;
        if (ovf_a[2] !== 1'b1 || bcd_a[2] !== 20'h02345) begin
            errors++;
            $display("FAIL ovf_12345: got ovf=%b bcd=%h want 1 2345", ovf_a[2], bcd_a[2]);
        end
        run_conv(2, 16'd42, lat);
        checks++;
        if (ovf_a[2] !== 1'b0 || bcd_a[2] !== 20'h00042) begin
            errors++;
            $display("FAIL ovf_clear: got ovf=%b bcd=%h want 0 0042", ovf_a[2], bcd_a[2]);
        end
    endtask

    task automatic test_back_to_back();
        int lat1;
        int lat2;
        @(negedge clk);
        start_a[0] = 1'b1;
        bin_a[0]   = 16'd100;
        @(negedge clk);
        bin_a[0] = 16'd200;
        lat1 = 0;
        while (done_a[0] !== 1'b1 && lat1 < 40) begin
            @(negedge clk);
            lat1++;
        end
        checks++;
        if (lat1 !== 17 || bcd_a[0] !== 20'h00100) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d bcd=%h want 17 00100", lat1, bcd_a[0]);
        end
        checks++;
        if (busy_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: got busy=%b want 1", busy_a[0]);
        end
        start_a[0] = 1'b0;
        lat2 = 0;
        do begin
            @(negedge clk);
            lat2++;
            if (lat2 == 8) begin
                checks++;
                if (bcd_a[0] !== 20'h00100) begin
                    errors++;
                    $display("FAIL b2b_hold: got %h want 00100", bcd_a[0]);
                end
            end
        end while (done_a[0] !== 1'b1 && lat2 < 40);
        checks++;
        if (lat2 !== 17 || bcd_a[0] !== 20'h00200) begin
            errors++;
            $display("FAIL b2b_second: got gap=%0d bcd=%h want 17 00200", lat2, bcd_a[0]);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        int seen;
        @(negedge clk);
        start_a[0] = 1'b1;
        bin_a[0]   = 16'd300;
        @(negedge clk);
        start_a[0] = 1'b0;
        lat = 0;
        while (done_a[0] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 5) begin
                start_a[0] = 1'b1;
                bin_a[0]   = 16'd999;
            end else begin
                start_a[0] = 1'b0;
            end
        end
        checks++;
        if (lat !== 17 || bcd_a[0] !== 20'h00300) begin
            errors++;
            $display("FAIL ignore_start: got lat=%0d bcd=%h want 17 00300", lat, bcd_a[0]);
        end
        start_a[0] = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_a[0] === 1'b1 || busy_a[0] === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL ignore_no_extra: got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        @(negedge clk);
        start_a[0] = 1'b1;
        bin_a[0]   = 16'd777;
        @(negedge clk);
        start_a[0] = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (busy_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy_before: got %b want 1", busy_a[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_a[0] !== 1'b0 || done_a[0] !== 1'b0 || bcd_a[0] !== 20'h00000) begin
            errors++;
            $display("FAIL midrst_clear: got busy=%b done=%b bcd=%h want 0 0 00000",
                     busy_a[0], done_a[0], bcd_a[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_a[0] === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midrst_no_done: got %0d pulses want 0", seen);
        end
        run_conv(0, 16'd500, lat);
        checks++;
        if (lat !== 17 || bcd_a[0] !== 20'h00500) begin
            errors++;
            $display("FAIL after_reset: got lat=%0d bcd=%h want 17 00500", lat, bcd_a[0]);
        end
    endtask

    // Guard against a hang anywhere in the sequence.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Test sequence.
    initial begin
        test_reset();
        test_unsigned_max();
        test_unsigned_values();
        test_signed();
        test_overflow();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
